cpu_phase_sequencer: RTL and testbench
======================================

Name: cpu_phase_sequencer

Overview:
Central control sequencer for the cpu15 core. It steps each instruction through four phases: fetch, decode, execute and writeback. It owns the program counter P_COUNT that addresses the 16-entry instruction ROM. It also applies jumps, handles hlt, and counts retired instructions. It replaces free-running per-phase clocks with one-hot phase enables on a single clock.

Parameters:
PC_WIDTH, 8, program counter width; the ROM uses P_COUNT[3:0].
CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RESET  input  1  synchronous, active-high reset.
START  input  1  level; starts or restarts execution from IDLE or HALT.
STOP  input  1  level; request to return to IDLE at the next instruction boundary.
HLT_DET  input  1  decoder flag: current instruction is hlt; valid in DECODE.
JUMP_TAKEN  input  1  execute flag: branch/jump taken; valid in EXEC.
JUMP_ADDR  input  PC_WIDTH  jump target; valid in EXEC.
EN_FT  output  1  fetch enable; ROM output register loads when high.
EN_DC  output  1  decode enable.
EN_EX  output  1  execute enable.
EN_WB  output  1  writeback enable.
P_COUNT  output  PC_WIDTH  program counter.
HALTED  output  1  high while in HALT.
STATE  output  3  current state encoding, for debug.
INSN_COUNT  output  CNT_WIDTH  retired-instruction count; saturates.

Behaviour:
- Clock and reset are fixed: one clock CLK; RESET is synchronous and active-high.
- RESET high (takes priority over all other inputs, in any state, including mid-instruction):
  - next state IDLE;
  - P_COUNT=0, INSN_COUNT=0, HALTED=0;
  - all EN_* = 0; jump latch cleared.
- States (encodings in package): IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5; PAUSE=6 only with the optional feature.
- EN_* are registered, one-hot, and high for exactly the one cycle the state is FETCH/DECODE/EXEC/WB. All are 0 in IDLE, HALT and PAUSE.
- IDLE:
  - START=1 -> FETCH; EN_FT high in the cycle after START is sampled.
  - P_COUNT is held, so a START after STOP resumes at the held P_COUNT.
- FETCH -> DECODE unconditionally. The instruction at P_COUNT is valid during DECODE.
- DECODE:
  - HLT_DET=1 -> HALT: INSN_COUNT +1, P_COUNT unchanged, no EXEC/WB issued.
  - Otherwise -> EXEC.
- EXEC:
  - Latch JUMP_TAKEN and JUMP_ADDR.
  - -> WB.
- WB:
  - P_COUNT <= latched JUMP_ADDR if the latched jump is set, else P_COUNT+1 modulo 2^PC_WIDTH (0xFF -> 0x00).
  - INSN_COUNT +1, saturating at all-ones; never wraps.
  - Jump latch cleared.
  - Next state: IDLE if STOP=1; else PAUSE if step mode is active; else FETCH.
- STOP is sampled only in WB. An instruction in flight always completes.
- HALT:
  - HALTED=1; stays until RESET or START.
  - START=1 -> HALTED=0, P_COUNT=0, next state FETCH.
  - STOP has no effect in HALT.
- START is ignored in FETCH/DECODE/EXEC/WB.
- JUMP_TAKEN and HLT_DET are ignored outside EXEC and DECODE respectively.
- Throughput: 4 cycles per non-halting instruction; no bubbles between instructions in run mode.

Optional Feature:
Macro SINGLE_STEP_EN.
- Defined:
  - Adds inputs STEP_MODE (level) and STEP (level, 1 bit).
  - In WB with STOP=0 and STEP_MODE=1 -> PAUSE.
  - PAUSE: STEP=1 -> FETCH; STOP=1 -> IDLE (STOP wins if both are high); STATE=6.
  - STEP_MODE=0 while in PAUSE: resume to FETCH next cycle.
- Undefined:
  - No STEP_MODE/STEP ports; PAUSE state not generated.
  - WB -> FETCH or IDLE only.

Decomposition:
- Package cpu15_seq_pkg:
  - state encoding constants (IDLE..PAUSE) and state width 3;
  - default PC_WIDTH and CNT_WIDTH;
  - opcode constants for hlt (4'b1111), jmp (4'b1100) and je (4'b1011), for use by the bench and decoder.
- One natural sub-module: seq_sat_counter, a CNT_WIDTH saturating counter with synchronous clear and increment enable, used for INSN_COUNT.

Test Plan:
- Reset/start: RESET for 2 cycles, then START=1 for 1 cycle -> EN_FT=1 at cycle +1, then EN_DC, EN_EX, EN_WB on consecutive cycles. After WB, P_COUNT=1 and INSN_COUNT=1.
- Loop: jump from PC=13 to JUMP_ADDR=8 for 3 iterations -> P_COUNT sequence 13, 8, 9, ...; no bubble cycles.
- Halt: HLT_DET=1 in DECODE at PC=14 -> HALT with HALTED=1, P_COUNT=14, INSN_COUNT incremented, no EN_EX. Then START -> P_COUNT=0 and FETCH.
- Wrap: preload P_COUNT to 0xFF via jump -> next sequential P_COUNT=0x00. Force INSN_COUNT near all-ones -> it holds at 0xFFFF.
- STOP and reset: STOP=1 asserted in DECODE -> instruction finishes its WB, then IDLE with P_COUNT held; START resumes at that PC. RESET asserted in EXEC -> next cycle IDLE, all outputs at reset values, pending jump discarded.
- SINGLE_STEP_EN build: STEP_MODE=1 -> PAUSE after each WB; each STEP pulse executes exactly one instruction (4 enables). STEP and STOP together -> IDLE.

Source files
------------

// File: rtl/cpu15_seq_pkg.sv
// Shared definitions for the cpu15 phase sequencer: state encodings, default widths
// and the opcodes the sequencer cares about.
package cpu15_seq_pkg;

    localparam int STATE_W       = 3;
    localparam int DEF_PC_WIDTH  = 8;
    localparam int DEF_CNT_WIDTH = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_PAUSE  = 3'd6
    } seq_state_e;

    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_JE  = 4'b1011;

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seq_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cpu_phase_sequencer.sv
// cpu15 phase sequencer: steps instructions through FETCH/DECODE/EXEC/WB with one-hot enables.
// Optional single-step support (STEP_MODE/STEP ports, PAUSE state) with SINGLE_STEP_EN.
module cpu_phase_sequencer
    import cpu15_seq_pkg::*;
#(
    parameter int PC_WIDTH  = DEF_PC_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 STOP,
    input  logic                 HLT_DET,
    input  logic                 JUMP_TAKEN,
    input  logic [PC_WIDTH-1:0]  JUMP_ADDR,
`ifdef SINGLE_STEP_EN
    input  logic                 STEP_MODE,
    input  logic                 STEP,
`endif
    output logic                 EN_FT,
    output logic                 EN_DC,
    output logic                 EN_EX,
    output logic                 EN_WB,
    output logic [PC_WIDTH-1:0]  P_COUNT,
    output logic                 HALTED,
    output logic [STATE_W-1:0]   STATE,
    output logic [CNT_WIDTH-1:0] INSN_COUNT
);

    seq_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                jmp_q, jmp_d;
    logic [PC_WIDTH-1:0] jaddr_q, jaddr_d;
    logic [3:0]          en_q, en_d;
    logic                halted_q, halted_d;
    logic                retire;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        jmp_d   = jmp_q;
        jaddr_d = jaddr_q;
        retire  = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (START) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (HLT_DET) begin
                    state_d = ST_HALT;
                    retire  = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                jmp_d   = JUMP_TAKEN;
                jaddr_d = JUMP_ADDR;
                state_d = ST_WB;
            end
            ST_WB: begin
                pc_d   = jmp_q ? jaddr_q : pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
                jmp_d  = 1'b0;
                retire = 1'b1;
                if (STOP) begin
                    state_d = ST_IDLE;
`ifdef SINGLE_STEP_EN
                end else if (STEP_MODE) begin
                    state_d = ST_PAUSE;
`endif
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (START) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
`ifdef SINGLE_STEP_EN
            // Leaving step mode while paused behaves like an implicit STEP.
            ST_PAUSE: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                end else if (STEP || !STEP_MODE) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        en_d     = {state_d == ST_WB, state_d == ST_EXEC, state_d == ST_DECODE, state_d == ST_FETCH};
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            jmp_q    <= 1'b0;
            jaddr_q  <= '0;
            en_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            jmp_q    <= jmp_d;
            jaddr_q  <= jaddr_d;
            en_q     <= en_d;
            halted_q <= halted_d;
        end
    end

    seq_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_insn_cnt (
        .clk_i   (CLK),
        .clr_i   (RESET),
        .inc_i   (retire),
        .count_o (INSN_COUNT)
    );

    assign EN_FT   = en_q[0];
    assign EN_DC   = en_q[1];
    assign EN_EX   = en_q[2];
    assign EN_WB   = en_q[3];
    assign P_COUNT = pc_q;
    assign HALTED  = halted_q;
    assign STATE   = state_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Bench for cpu_phase_sequencer: directed scenarios then random traffic, every cycle
// compared against an instruction-level model. Build with SINGLE_STEP_EN to cover PAUSE.
module tb_cpu_phase_sequencer;

    localparam int PW      = 8;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RESET, START, STOP, HLT_DET, JUMP_TAKEN;
    logic [PW-1:0] JUMP_ADDR;
    logic          STEP_MODE, STEP;
    logic          EN_FT, EN_DC, EN_EX, EN_WB, HALTED;
    logic [PW-1:0] P_COUNT;
    logic [2:0]    STATE;
    logic [CW-1:0] INSN_COUNT;

    int vectors     = 0;
    int miscompares = 0;

    // model: mode 0=idle 1=running 2=halted 3=paused; phase 0..3 within an instruction
    int m_mode, m_phase, m_pc, m_cnt, m_ja;
    bit m_jt;

    cpu_phase_sequencer #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .STOP       (STOP),
        .HLT_DET    (HLT_DET),
        .JUMP_TAKEN (JUMP_TAKEN),
        .JUMP_ADDR  (JUMP_ADDR),
`ifdef SINGLE_STEP_EN
        .STEP_MODE  (STEP_MODE),
        .STEP       (STEP),
`endif
        .EN_FT      (EN_FT),
        .EN_DC      (EN_DC),
        .EN_EX      (EN_EX),
        .EN_WB      (EN_WB),
        .P_COUNT    (P_COUNT),
        .HALTED     (HALTED),
        .STATE      (STATE),
        .INSN_COUNT (INSN_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic retire_one();
        if (m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic model_update();
        bit sm, st;
        sm = 1'b0;
        st = 1'b0;
`ifdef SINGLE_STEP_EN
        sm = STEP_MODE;
        st = STEP;
`endif
        if (RESET) begin
            m_mode = 0; m_pc = 0; m_cnt = 0; m_jt = 0; m_ja = 0;
            return;
        end
        case (m_mode)
            0: if (START) begin m_mode = 1; m_phase = 0; end
            2: if (START) begin m_mode = 1; m_phase = 0; m_pc = 0; end
            3: begin
                if (STOP) m_mode = 0;
                else if (st || !sm) begin m_mode = 1; m_phase = 0; end
            end
            default: begin
                case (m_phase)
                    0: m_phase = 1;
                    1: begin
                        if (HLT_DET) begin retire_one(); m_mode = 2; end
                        else m_phase = 2;
                    end
                    2: begin m_jt = JUMP_TAKEN; m_ja = int'(JUMP_ADDR); m_phase = 3; end
                    default: begin
                        m_pc = m_jt ? m_ja : (m_pc + 1) % (1 << PW);
                        m_jt = 0;
                        retire_one();
                        if (STOP) m_mode = 0;
                        else if (sm) m_mode = 3;
                        else m_phase = 0;
                    end
                endcase
            end
        endcase
    endtask

    task automatic cycle();
        int exp_state;
        logic [3:0] exp_en;
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        exp_state = (m_mode == 0) ? 0 : (m_mode == 2) ? 5 : (m_mode == 3) ? 6 : m_phase + 1;
        exp_en = (m_mode == 1) ? 4'(1 << m_phase) : 4'd0;
        check("state", 32'(STATE), 32'(exp_state));
        check("enables", 32'({EN_WB, EN_EX, EN_DC, EN_FT}), 32'(exp_en));
        check("p_count", 32'(P_COUNT), 32'(m_pc));
        check("halted", 32'(HALTED), 32'(m_mode == 2));
        check("insn_count", 32'(INSN_COUNT), 32'(m_cnt));
    endtask

    // Call with the sequencer in FETCH; irrelevant flags carry random noise.
    task automatic run_insn(input bit hlt, input bit jt, input logic [PW-1:0] ja);
        HLT_DET = 1'($urandom); JUMP_TAKEN = 1'($urandom); JUMP_ADDR = PW'($urandom);
        cycle();
        HLT_DET = hlt; JUMP_TAKEN = 1'($urandom);
        cycle();
        if (hlt) begin HLT_DET = 1'b0; return; end
        HLT_DET = 1'($urandom); JUMP_TAKEN = jt; JUMP_ADDR = ja;
        cycle();
        JUMP_TAKEN = 1'($urandom); JUMP_ADDR = PW'($urandom);
        cycle();
        HLT_DET = 1'b0; JUMP_TAKEN = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; STOP = 1'b0; HLT_DET = 1'b0;
        JUMP_TAKEN = 1'b0; JUMP_ADDR = '0; STEP_MODE = 1'b0; STEP = 1'b0;
        m_mode = 0; m_phase = 0; m_pc = 0; m_cnt = 0; m_jt = 0; m_ja = 0;
        @(negedge CLK);
        cycle(); cycle();
        RESET = 1'b0;
        cycle();

        // start and first instruction
        START = 1'b1; cycle(); START = 1'b0;
        check("first_fetch", 32'(EN_FT), 32'd1);
        run_insn(1'b0, 1'b0, '0);
        check("first_pc", 32'(P_COUNT), 32'd1);
        check("first_cnt", 32'(INSN_COUNT), 32'd1);

        // loop 13 -> 8 three times
        run_insn(1'b0, 1'b1, PW'(13));
        for (int it = 0; it < 3; it++) begin
            for (int g = 0; g < 20 && m_pc != 13; g++) run_insn(1'b0, 1'b0, '0);
            check("loop_top", 32'(P_COUNT), 32'd13);
            run_insn(1'b0, 1'b1, PW'(8));
            check("loop_back", 32'(P_COUNT), 32'd8);
        end

        // halt at 14, then restart from 0
        for (int g = 0; g < 20 && m_pc != 14; g++) run_insn(1'b0, 1'b0, '0);
        run_insn(1'b1, 1'b0, '0);
        STOP = 1'b1; cycle(); cycle(); STOP = 1'b0;
        check("halt_flag", 32'(HALTED), 32'd1);
        check("halt_pc", 32'(P_COUNT), 32'd14);
        START = 1'b1; cycle(); START = 1'b0;
        check("restart_pc", 32'(P_COUNT), 32'd0);

        // PC wrap
        run_insn(1'b0, 1'b1, 8'hFF);
        run_insn(1'b0, 1'b0, '0);
        check("pc_wrap", 32'(P_COUNT), 32'd0);

        // STOP raised in DECODE: instruction completes, then idle with PC held
        cycle();
        STOP = 1'b1; cycle(); cycle(); cycle(); cycle(); cycle();
        STOP = 1'b0;
        check("stop_idle", 32'(STATE), 32'd0);
        check("stop_pc", 32'(P_COUNT), 32'd1);
        START = 1'b1; cycle(); START = 1'b0;
        run_insn(1'b0, 1'b0, '0);
        check("resume_pc", 32'(P_COUNT), 32'd2);

        // RESET in EXEC discards the pending jump
        cycle(); cycle();
        JUMP_TAKEN = 1'b1; JUMP_ADDR = 8'h55; RESET = 1'b1; cycle();
        RESET = 1'b0; JUMP_TAKEN = 1'b0;
        check("rst_exec_state", 32'(STATE), 32'd0);
        START = 1'b1; cycle(); START = 1'b0;
        run_insn(1'b0, 1'b0, '0);
        check("rst_no_jump", 32'(P_COUNT), 32'd1);

`ifdef SINGLE_STEP_EN
        STEP_MODE = 1'b1;
        run_insn(1'b0, 1'b0, '0);
        cycle(); cycle();
        check("pause_state", 32'(STATE), 32'd6);
        STEP = 1'b1; cycle(); STEP = 1'b0;
        run_insn(1'b0, 1'b0, '0);
        check("step_pc", 32'(P_COUNT), 32'd3);
        STEP = 1'b1; STOP = 1'b1; cycle(); STEP = 1'b0; STOP = 1'b0;
        check("step_stop_idle", 32'(STATE), 32'd0);
        STEP_MODE = 1'b0;
        START = 1'b1; cycle(); START = 1'b0;
`endif

        // count saturation
        for (int i = 0; i < CNT_MAX + 5; i++) run_insn(1'b0, 1'($urandom), PW'($urandom));
        check("cnt_saturate", 32'(INSN_COUNT), 32'(CNT_MAX));

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            RESET      = ($urandom_range(0, 63) == 0);
            START      = ($urandom_range(0, 3) == 0);
            STOP       = ($urandom_range(0, 7) == 0);
            HLT_DET    = ($urandom_range(0, 7) == 0);
            JUMP_TAKEN = 1'($urandom);
            JUMP_ADDR  = PW'($urandom);
`ifdef SINGLE_STEP_EN
            STEP_MODE  = ($urandom_range(0, 2) == 0);
            STEP       = ($urandom_range(0, 2) == 0);
`endif
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
